// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Write-source codes are ordered so a larger code wins a same-address conflict.
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WR0  = 2'd1,
    SRC_WR1  = 2'd2,
    SRC_LINK = 2'd3
  } wr_src_e;
endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves wr0/wr1/link into one winning write per register address.
// Hit vector and per-address data feed the array update, bypass and lock clear.
module regfile_wr_arb import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINK_IDX = NUM_REGS-1,
  parameter int ZERO_R0  = 0
) (
  input  logic                               i_wr0_en,
  input  logic [ADDR_W-1:0]                  i_wr0_addr,
  input  logic [DATA_W-1:0]                  i_wr0_data,
  input  logic                               i_wr1_en,
  input  logic [ADDR_W-1:0]                  i_wr1_addr,
  input  logic [DATA_W-1:0]                  i_wr1_data,
  input  logic                               i_link_en,
  input  logic [DATA_W-1:0]                  i_link_data,
  output logic [NUM_REGS-1:0]                o_hit,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    o_data
);
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (ZERO_R0 != 0 && g == 0) begin : g_zero
      assign o_hit[g]  = 1'b0;
      assign o_data[g] = '0;
    end else begin : g_arb
      wr_src_e w_src;
      always_comb begin
        w_src = SRC_NONE;
        if (i_link_en && LINK_IDX == g)          w_src = SRC_LINK;
        else if (i_wr1_en && i_wr1_addr == ADDR_W'(g)) w_src = SRC_WR1;
        else if (i_wr0_en && i_wr0_addr == ADDR_W'(g)) w_src = SRC_WR0;
      end
      assign o_hit[g] = (w_src != SRC_NONE);
      always_comb begin
        case (w_src)
          SRC_LINK: o_data[g] = i_link_data;
          SRC_WR1:  o_data[g] = i_wr1_data;
          SRC_WR0:  o_data[g] = i_wr0_data;
          default:  o_data[g] = '0;
        endcase
      end
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Two-read register file with three write sources, pending-write lock bits,
// optional write-to-read bypass and a one-register-per-cycle clear sweep.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RET_IDX  = 1,
  parameter int LINK_IDX = NUM_REGS-1,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic              rd_a_ready,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_b_ready,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              lock_ok,
  output logic              busy_any,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] ret_data
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_lock;
  clr_state_e                      r_state;
  logic [ADDR_W-1:0]               r_clr_idx;

  logic                            w_idle;
  logic [NUM_REGS-1:0]             w_hit;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_wdata;
  logic [NUM_REGS-1:0]             w_lock_nxt;

  assign w_idle = (r_state == IDLE);

  // Gating the enables here drops every write while the sweep runs.
  regfile_wr_arb #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .LINK_IDX(LINK_IDX), .ZERO_R0(ZERO_R0)
  ) u_arb (
    .i_wr0_en   (wr0_en & w_idle),
    .i_wr0_addr (wr0_addr),
    .i_wr0_data (wr0_data),
    .i_wr1_en   (wr1_en & w_idle),
    .i_wr1_addr (wr1_addr),
    .i_wr1_data (wr1_data),
    .i_link_en  (link_en & w_idle),
    .i_link_data(link_data),
    .o_hit      (w_hit),
    .o_data     (w_wdata)
  );

  // With ZERO_R0 the r0 lock bit is never set, so a lock on r0 always passes.
  assign lock_ok = lock_en & w_idle & ~r_lock[lock_addr];

  always_comb begin
    w_lock_nxt = r_lock & ~w_hit;
    if (lock_ok && !(ZERO_R0 != 0 && lock_addr == '0)) w_lock_nxt[lock_addr] = 1'b1;
  end

  function automatic logic [DATA_W-1:0] f_rd_data(input logic [ADDR_W-1:0] addr);
    if (ZERO_R0 != 0 && addr == '0) return '0;
    if (BYPASS != 0 && w_hit[addr]) return w_wdata[addr];
    return r_regs[addr];
  endfunction

  function automatic logic f_rd_ready(input logic [ADDR_W-1:0] addr);
    if (!w_idle) return 1'b0;
    if (ZERO_R0 != 0 && addr == '0) return 1'b1;
    if (BYPASS != 0 && w_hit[addr]) return 1'b1;
    return ~r_lock[addr];
  endfunction

  assign rd_a_data  = f_rd_data(rd_a_addr);
  assign rd_b_data  = f_rd_data(rd_b_addr);
  assign rd_a_ready = f_rd_ready(rd_a_addr);
  assign rd_b_ready = f_rd_ready(rd_b_addr);
  assign busy_any   = |r_lock;
  assign clr_busy   = ~w_idle;
  assign ret_data   = r_regs[RET_IDX];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs    <= '0;
      r_lock    <= '0;
      r_state   <= IDLE;
      r_clr_idx <= '0;
    end else if (r_state == IDLE) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_hit[i]) r_regs[i] <= w_wdata[i];
      r_lock <= w_lock_nxt;
      if (clr_req) begin
        r_state   <= CLEAR;
        r_clr_idx <= '0;
      end
    end else begin
      r_regs[r_clr_idx] <= '0;
      r_lock[r_clr_idx] <= 1'b0;
      r_clr_idx         <= r_clr_idx + 1'b1;
      if (r_clr_idx == ADDR_W'(NUM_REGS-1)) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values queued at stimulus time,
// popped and asserted when the corresponding output is sampled.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd_a_addr = '0, rd_b_addr = '0;
  logic [31:0] rd_a_data, rd_b_data, z_a_data, z_b_data;
  logic        rd_a_ready, rd_b_ready, z_a_ready, z_b_ready;
  logic        wr0_en = 0, wr1_en = 0, link_en = 0, lock_en = 0, clr_req = 0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0, lock_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0, link_data = '0;
  logic        lock_ok, busy_any, clr_busy, z_lock_ok, z_busy_any, z_clr_busy;
  logic [31:0] ret_data, z_ret_data;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst(rst),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_ready(rd_a_ready),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_ready(rd_b_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .link_en(link_en), .link_data(link_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .lock_ok(lock_ok),
    .busy_any(busy_any), .clr_req(clr_req), .clr_busy(clr_busy),
    .ret_data(ret_data)
  );

  regfile_sb #(.ZERO_R0(1)) u_z (
    .clk(clk), .rst(rst),
    .rd_a_addr(rd_a_addr), .rd_a_data(z_a_data), .rd_a_ready(z_a_ready),
    .rd_b_addr(rd_b_addr), .rd_b_data(z_b_data), .rd_b_ready(z_b_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .link_en(link_en), .link_data(link_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .lock_ok(z_lock_ok),
    .busy_any(z_busy_any), .clr_req(clr_req), .clr_busy(z_clr_busy),
    .ret_data(z_ret_data)
  );

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    wr0_en = 0; wr1_en = 0; link_en = 0; lock_en = 0; clr_req = 0;
  endtask

  initial begin
    int cnt;
    // reset state
    #2;
    push("rst_rda", 0);     chk(rd_a_data);
    push("rst_rdy", 1);     chk({31'b0, rd_a_ready});
    push("rst_lockok", 0);  chk({31'b0, lock_ok});
    push("rst_busy", 0);    chk({31'b0, busy_any});
    push("rst_clrbusy", 0); chk({31'b0, clr_busy});
    push("rst_ret", 0);     chk(ret_data);
    tick; rst = 1; tick;

    // basic write, same-cycle bypass then stored value
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF; rd_a_addr = 3; #1;
    push("byp_3", 32'hDEADBEEF); chk(rd_a_data);
    tick; idle_in; #1;
    push("rd_3", 32'hDEADBEEF); chk(rd_a_data);
    push("rdy_3", 1);           chk({31'b0, rd_a_ready});

    // wr1 beats wr0, link beats wr1
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h22;
    tick; idle_in; rd_a_addr = 5; #1;
    push("prio_wr1", 32'h22); chk(rd_a_data);
    link_en = 1; link_data = 32'h33; wr1_en = 1; wr1_addr = 31; wr1_data = 32'h44;
    tick; idle_in; rd_b_addr = 31; #1;
    push("prio_link", 32'h33); chk(rd_b_data);

    // lock / relock / write-release
    lock_en = 1; lock_addr = 7; #1;
    push("lock7_ok", 1); chk({31'b0, lock_ok});
    tick; lock_en = 0; rd_a_addr = 7; #1;
    push("lock7_busy", 1); chk({31'b0, busy_any});
    push("lock7_rdy", 0);  chk({31'b0, rd_a_ready});
    lock_en = 1; #1;
    push("relock7", 0); chk({31'b0, lock_ok});
    tick; lock_en = 0; wr0_en = 1; wr0_addr = 7; wr0_data = 32'h99; #1;
    push("byp_rdy7", 1); chk({31'b0, rd_a_ready});
    tick; idle_in; #1;
    push("rel7_rdy", 1);  chk({31'b0, rd_a_ready});
    push("rel7_busy", 0); chk({31'b0, busy_any});
    push("rel7_data", 32'h99); chk(rd_a_data);

    // lock and write same address: data lands, lock stays
    lock_en = 1; lock_addr = 9; wr1_en = 1; wr1_addr = 9; wr1_data = 32'h55;
    tick; idle_in; rd_a_addr = 9; #1;
    push("lw9_data", 32'h55); chk(rd_a_data);
    push("lw9_rdy", 0);       chk({31'b0, rd_a_ready});
    push("lw9_busy", 1);      chk({31'b0, busy_any});

    // fill, lock 4, sweep
    for (int i = 0; i < 32; i++) begin
      wr0_en = 1; wr0_addr = 5'(i); wr0_data = 32'(i + 1); tick;
    end
    idle_in; lock_en = 1; lock_addr = 4; #1;
    push("fill_ret", 2); chk(ret_data);
    push("lock4_ok", 1); chk({31'b0, lock_ok});
    tick; lock_en = 0; clr_req = 1; tick; clr_req = 0;
    wr0_en = 1; wr0_addr = 2; wr0_data = 32'hBAD; lock_en = 1; lock_addr = 3;
    rd_a_addr = 20; #1;
    push("clr_lockok", 0); chk({31'b0, lock_ok});
    push("clr_rdy", 0);    chk({31'b0, rd_a_ready});
    push("clr_rddata", 21); chk(rd_a_data);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!clr_busy) break;
      cnt++;
      tick;
    end
    idle_in; rd_a_addr = 2; rd_b_addr = 31; #1;
    push("clr_cycles", 32); chk(32'(cnt));
    push("clr_r2", 0);      chk(rd_a_data);
    push("clr_r31", 0);     chk(rd_b_data);
    push("clr_busy_any", 0); chk({31'b0, busy_any});
    push("clr_ret", 0);     chk(ret_data);

    // async reset mid-write
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'h77; tick;
    wr0_data = 32'h88; rd_b_addr = 1; #2;
    push("pre_rst_ret", 32'h77); chk(ret_data);
    rst = 0; #1;
    push("arst_ret", 0); chk(ret_data);
    idle_in; #1;
    push("arst_rdb", 0); chk(rd_b_data);
    tick; rst = 1; tick;

    // async reset mid-sweep
    wr0_en = 1; wr0_addr = 20; wr0_data = 32'h5; tick;
    idle_in; clr_req = 1; tick; clr_req = 0; tick; tick; rd_b_addr = 20; #2;
    push("sweep_mid", 1); chk({31'b0, clr_busy});
    rst = 0; #1;
    push("arst_clrbusy", 0); chk({31'b0, clr_busy});
    push("arst_r20", 0);     chk(rd_b_data);
    push("arst_rdy", 1);     chk({31'b0, rd_b_ready});
    tick; rst = 1; tick;

    // ZERO_R0 instance: r0 ignores writes and locks
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFF; rd_a_addr = 0; #1;
    push("z_byp_r0", 0); chk(z_a_data);
    tick; idle_in; #1;
    push("z_r0", 0);     chk(z_a_data);
    push("z_r0_rdy", 1); chk({31'b0, z_a_ready});
    lock_en = 1; lock_addr = 0; #1;
    push("z_lock0_ok", 1); chk({31'b0, z_lock_ok});
    tick; idle_in; #1;
    push("z_lock0_busy", 0); chk({31'b0, z_busy_any});
    push("nz_lock0_busy", 1); chk({31'b0, busy_any});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
